// File: rtl/spsram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM controller.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package spsram_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Read-response buffer depth and the width of its occupancy counter.
    localparam int RSP_DEPTH = 3;
    localparam int RSP_CNT_W = $clog2(RSP_DEPTH + 1);

    // Number of byte lanes in a data word.
    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/spsram_rsp_fifo.sv
// In-order read-response buffer, RSP_DEPTH entries deep.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: a push is dropped only if full with no pop; the controller never does that.
//
// Ports: cpuclk/cpurst_b clock and async active-low reset; push/push_dat write side;
// pop/head_dat read side (head_dat is the oldest entry); empty flag and entry count.
module spsram_rsp_fifo
    import spsram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  cpuclk,
    input  logic                  cpurst_b,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_dat,
    output logic                  empty,
    output logic [RSP_CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [RSP_CNT_W-1:0] CNT_FULL = RSP_CNT_W'(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    // Depth is not a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign do_pop   = pop & ~empty;
    // A full buffer can still take a push when the head leaves in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + RSP_CNT_W'(1);
                2'b01:   count <= count - RSP_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; only the pointers decide what is valid.
    always_ff @(posedge cpuclk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/spsram_128_ctrl.sv
// Single-port SRAM initiator: request channel -> SRAM cycles, read data -> response channel.
// Latency: SRAM pins are combinational from the accepted request; read response 2 cycles after accept.
// Backpressure: req_rdy drops once buffered plus in-flight reads reach RSP_DEPTH; never combinational on rsp_rdy.
//
// Ports: cpuclk/cpurst_b clock and async active-low reset; req_* valid/ready request
// (wr, word addr, wdata, active-high byte enables); rsp_* valid/ready read data;
// init_done high once traffic is accepted; sram_* macro pins (active-low cen/wen, a, d, q).
module spsram_128_ctrl
    import spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 128,
    parameter int INIT_EN    = 1
) (
    input  logic                              cpuclk,
    input  logic                              cpurst_b,
    input  logic                              req_vld,
    output logic                              req_rdy,
    input  logic                              req_wr,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]             req_wdata,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] req_be,
    output logic                              rsp_vld,
    input  logic                              rsp_rdy,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              init_done,
    output logic                              sram_cen,
    output logic [byte_lanes(DATA_WIDTH)-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0]             sram_a,
    output logic [DATA_WIDTH-1:0]             sram_d,
    input  logic [DATA_WIDTH-1:0]             sram_q
);

    localparam int BE_W = byte_lanes(DATA_WIDTH);
    localparam logic [RSP_CNT_W:0] OCC_MAX = RSP_DEPTH[RSP_CNT_W:0];

    state_t                 state_q;
    state_t                 state_d;
    logic [ADDR_WIDTH-1:0]  init_cnt_q;
    logic                   rd_inflight_q;
    logic [ADDR_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  d_q;
    logic [RSP_CNT_W-1:0]   fifo_count;
    logic                   fifo_empty;
    logic [RSP_CNT_W:0]     occupancy;
    logic                   fire;
    logic                   rd_fire;

    assign init_done = (state_q == ST_RUN);
    // Reserve a buffer slot for every read already issued to the SRAM.
    assign occupancy = {1'b0, fifo_count} + {{RSP_CNT_W{1'b0}}, rd_inflight_q};
    assign req_rdy   = init_done & (occupancy < OCC_MAX);
    assign fire      = req_vld & req_rdy;
    assign rd_fire   = fire & ~req_wr;
    assign rsp_vld   = ~fifo_empty;

    always_comb begin
        state_d  = state_q;
        sram_cen = 1'b1;
        sram_wen = '1;
        sram_a   = a_q;
        sram_d   = d_q;
        case (state_q)
            ST_INIT: begin
                if (INIT_EN != 0) begin
                    sram_cen = 1'b0;
                    sram_wen = '0;
                    sram_a   = init_cnt_q;
                    sram_d   = '0;
                    if (init_cnt_q == '1) state_d = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sram_cen = ~fire;
                sram_wen = ~({BE_W{fire & req_wr}} & req_be);
                if (fire) begin
                    sram_a = req_addr;
                    sram_d = req_wdata;
                end
            end
            default: state_d = ST_INIT;
        endcase
        // The fill would otherwise start driving writes while reset is still held;
        // keep the macro deselected for the whole reset assertion.
        if (!cpurst_b) begin
            sram_cen = 1'b1;
            sram_wen = '1;
        end
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
            a_q           <= '0;
            d_q           <= '0;
        end else begin
            state_q       <= state_d;
            rd_inflight_q <= rd_fire;
            if (state_q == ST_INIT && INIT_EN != 0) init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
            // Remember the last driven address/data so idle cycles leave the pins still.
            if (!sram_cen) begin
                a_q <= sram_a;
                d_q <= sram_d;
            end
        end
    end

    // Q is valid the cycle after a read cycle, which is exactly when rd_inflight_q is set.
    spsram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .cpuclk   (cpuclk),
        .cpurst_b (cpurst_b),
        .push     (rd_inflight_q),
        .push_dat (sram_q),
        .pop      (rsp_vld & rsp_rdy),
        .head_dat (rsp_rdata),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: doc/spsram_128_ctrl.md
Name: spsram_128_ctrl

Overview:
- Initiator-side controller for the 128-bit single-port SRAM macro interface: active-low CEN, per-byte active-low WEN, address A, data D, read data Q one cycle after access.
- Converts a valid/ready request channel (read/write with byte enables) into SRAM port cycles.
- Returns read data on a valid/ready response channel through a 3-entry buffer.
- Optionally zero-fills the whole array after reset.
- Sits between the bus-slave logic and the SRAM wrapper.

Parameters:
- ADDR_WIDTH, 15, SRAM word-address width; array depth 2^ADDR_WIDTH.
- DATA_WIDTH, 128, word width; must be a multiple of 8.
- INIT_EN, 1, 1 = zero-fill every word after reset before accepting requests.

Ports:
- cpuclk  in  1  clock, all logic rising-edge.
- cpurst_b  in  1  asynchronous active-low reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  DATA_WIDTH/8  active-high byte enables (writes only).
- rsp_vld  out  1  read data valid.
- rsp_rdy  in  1  read data accepted.
- rsp_rdata  out  DATA_WIDTH  read data.
- init_done  out  1  high once ready for traffic; stays high until reset.
- sram_cen  out  1  SRAM chip enable, active low.
- sram_wen  out  DATA_WIDTH/8  SRAM byte write enables, active low.
- sram_a  out  ADDR_WIDTH  SRAM address.
- sram_d  out  DATA_WIDTH  SRAM write data.
- sram_q  in  DATA_WIDTH  SRAM read data, valid the cycle after a CEN-low read cycle.

Behaviour:
- Reset: one clock, cpuclk; reset is asynchronous and active-low on cpurst_b.
- Values during reset: state=INIT, init_cnt=0, FIFO empty, rd_inflight=0, init_done=0, req_rdy=0, rsp_vld=0, sram_cen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- FSM states: INIT -> RUN.
  - INIT with INIT_EN=1: each cycle drives sram_cen=0, sram_wen=all 0, sram_d=0, sram_a=init_cnt, then init_cnt++. After the cycle with init_cnt=2^ADDR_WIDTH-1, go to RUN and set init_done=1. This takes exactly 2^ADDR_WIDTH cycles; init_done rises at the edge ending the last fill write.
  - INIT with INIT_EN=0: go to RUN at the first edge after reset release; sram_cen stays 1 during that cycle.
- RUN SRAM drive is combinational from the accepted request: fire = req_vld & req_rdy.
  - sram_cen = !fire; sram_a = req_addr; sram_d = req_wdata.
  - sram_wen[i] = !(fire & req_wr & req_be[i]).
  - When sram_cen=1: sram_a and sram_d hold their last driven values (registered copies), so idle cycles do not toggle the pins.
- Write: one SRAM cycle, no response.
  - A write with req_be=0 is a legal no-op: CEN is still low, nothing is stored, no response.
- Read: the fire cycle sets rd_inflight=1. On the next edge sram_q is pushed into the response FIFO and rd_inflight clears, unless another read fires in that same cycle.
- Read latency: req fire at cycle N -> rsp_vld=1 at cycle N+2 (FIFO was empty) with rsp_rdata = Q.
- Response FIFO: 3 entries, in-order. rsp_vld = !empty; rsp_rdata = head entry. Pop on rsp_vld & rsp_rdy. Simultaneous push and pop is allowed; count is unchanged.
- Flow control: req_rdy = init_done & (fifo_count + rd_inflight < 3).
  - No combinational path from rsp_rdy to req_rdy.
  - Applies to writes too (simple, conservative).
  - Back-to-back reads with rsp_rdy=1 sustain 1 read per cycle.
  - With rsp_rdy=0, exactly 3 reads are accepted, then req_rdy=0.
- Read after write to the same address in the next cycle returns the new data.
- Reset mid-operation clears the FIFO and the in-flight read; lost responses are not replayed. INIT restarts from address 0.
- Requests presented while init_done=0 are not accepted (req_rdy=0); they are held by the requester.

Decomposition:
- Shared package spsram_ctrl_pkg holds:
  - state encoding (ST_INIT, ST_RUN);
  - RSP_DEPTH=3;
  - byte-lane count DATA_WIDTH/8.
- Sub-module spsram_rsp_fifo: DATA_WIDTH-wide, 3-deep synchronous FIFO with push/pop/count, on the same cpuclk/cpurst_b.

Test Plan:
- Reset release with INIT_EN=1, ADDR_WIDTH=4 -> 16 consecutive cycles of cen=0, wen=0, a=0..15, d=0; init_done=1 after cycle 16; req_rdy=1 the next cycle.
- Write addr 5, data 0x00112233_44556677_8899AABB_CCDDEEFF, be=0xFFFF; then read addr 5 -> rsp_rdata equals the written value, rsp_vld exactly 2 cycles after the read fire.
- Write addr 5, be=0x0001, data LSB 0x5A; read addr 5 -> only byte 0 changes to 0x5A, upper 15 bytes unchanged.
- rsp_rdy=0, 5 back-to-back reads of addr 0..4 -> exactly 3 accepted; req_rdy=0 from then on. Raise rsp_rdy -> data for addr 0,1,2 returned in order, then the remaining reads proceed.
- rsp_rdy=1, 8 back-to-back reads of addr 0..7 -> req_rdy never drops, 8 consecutive rsp_vld cycles, data in order.
- Assert cpurst_b=0 with 2 responses buffered -> rsp_vld=0 and sram_cen=1 immediately (asynchronous); after release, INIT restarts at address 0.
